// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter that shares one uart_tx serializer between NUM_REQ
// byte-stream requesters, with an optional idle gap after every packet.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int BITS_N     = 8,
  parameter int GAP_CYCLES = 0,
  parameter int GRANT_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*BITS_N-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [BITS_N-1:0]         tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic [GRANT_W-1:0]        grant_id,
  output logic                      busy
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [GRANT_W-1:0] grant_id_q, grant_id_d;
  logic [GRANT_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               busy_q, busy_d;

  logic               any_valid;
  logic [GRANT_W-1:0] rr_pick;
  logic               owner_valid;
  logic               owner_last;
  logic               xfer;

  function automatic logic [GRANT_W-1:0] wrap_inc(input logic [GRANT_W-1:0] idx);
    if (int'(idx) >= NUM_REQ - 1) begin
      return '0;
    end
    return idx + GRANT_W'(1);
  endfunction

  // Scan starting at rr_ptr so the requester that just finished goes last.
  always_comb begin
    any_valid = 1'b0;
    rr_pick   = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      int unsigned idx;
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!any_valid && req_valid[idx]) begin
        any_valid = 1'b1;
        rr_pick   = GRANT_W'(idx);
      end
    end
  end

  always_comb begin
    owner_valid = req_valid[grant_id_q];
    owner_last  = req_last[grant_id_q];
    xfer        = (state_q == SEND) && owner_valid && tx_ready;
  end

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    gap_cnt_d  = gap_cnt_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          grant_id_d = rr_pick;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (xfer && owner_last) begin
          rr_ptr_d = wrap_inc(grant_id_q);
          if (GAP_CYCLES > 0) begin
            state_d   = GAP;
            gap_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q + GAP_W'(1);
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      gap_cnt_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      gap_cnt_q  <= gap_cnt_d;
      busy_q     <= busy_d;
    end
  end

  // Owner is wired straight through in SEND; outputs are forced quiet while rst_n is low.
  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = '0;
    req_ready = '0;
    if (rst_n && (state_q == SEND)) begin
      tx_valid              = owner_valid;
      tx_data               = req_data[grant_id_q*BITS_N +: BITS_N];
      req_ready[grant_id_q] = tx_ready;
    end
  end

  assign grant_id = grant_id_q;
  assign busy     = busy_q && rst_n;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a GAP_CYCLES=0 instance fed by packet
// producers and a uart_tx-like ready responder, plus a GAP_CYCLES=3 instance.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst_n, rst_n_nx;

  logic [3:0]  rv, rl, rr0;
  logic [31:0] rd;
  logic [7:0]  txd0;
  logic        txv0, txr0;
  logic [1:0]  gid0;
  logic        busy0;

  logic [3:0]  rv3, rv3_nx, rl3, rr3;
  logic [31:0] rd3;
  logic [7:0]  txd3;
  logic        txv3, tr3;
  logic [1:0]  gid3;
  logic        busy3;

  logic [8:0]  pbuf [4][32];
  int          phead [4];
  int          ptail [4];
  logic        hold  [4];
  int          rdy_hi [4];
  int          rdy_wait;

  logic [7:0]  log_b [64];
  int          log_g [64];
  int          log_n;

  int          n_checks;
  int          n_fail;

  uart_tx_arbiter #(.NUM_REQ(4), .BITS_N(8), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv), .req_data(rd), .req_last(rl),
    .req_ready(rr0), .tx_data(txd0), .tx_valid(txv0), .tx_ready(txr0),
    .grant_id(gid0), .busy(busy0)
  );

  uart_tx_arbiter #(.NUM_REQ(4), .BITS_N(8), .GAP_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv3), .req_data(rd3), .req_last(rl3),
    .req_ready(rr3), .tx_data(txd3), .tx_valid(txv3), .tx_ready(tr3),
    .grant_id(gid3), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic load(input int i, input logic [7:0] b, input logic last);
    pbuf[i][ptail[i]] = {last, b};
    ptail[i]++;
  endtask

  // One clock: drive at negedge, settle, then record what the next posedge accepts.
  task automatic step();
    @(negedge clk);
    rst_n = rst_n_nx;
    rv3   = rv3_nx;
    for (int i = 0; i < 4; i++) begin
      if (phead[i] < ptail[i]) begin
        rd[i*8 +: 8] = pbuf[i][phead[i]][7:0];
        rl[i]        = pbuf[i][phead[i]][8];
        rv[i]        = !hold[i];
      end else begin
        rd[i*8 +: 8] = 8'h00;
        rl[i]        = 1'b0;
        rv[i]        = 1'b0;
      end
    end
    if (!rst_n) rdy_wait = 0;
    txr0 = (rdy_wait == 0);
    #1;
    if (rst_n && txv0 && txr0) begin
      if (log_n < 64) begin
        log_b[log_n] = txd0;
        log_g[log_n] = int'(gid0);
      end
      log_n++;
      rdy_wait = 2;
    end else if (rdy_wait > 0) begin
      rdy_wait--;
    end
    for (int i = 0; i < 4; i++) begin
      if (rst_n && rr0[i]) begin
        rdy_hi[i]++;
        if (rv[i]) phead[i]++;
      end
    end
  endtask

  task automatic run_bytes(input string tag, input int target);
    int budget;
    budget = 0;
    while (log_n < target && budget < 300) begin
      step();
      budget++;
    end
    check({tag, "_count"}, log_n, target);
  endtask

  task automatic expect_log(input string tag, input int idx, input int g, input logic [7:0] b);
    check($sformatf("%s_g%0d", tag, idx), log_g[idx], g);
    check($sformatf("%s_b%0d", tag, idx), log_b[idx], b);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int viol;
    int eb [8];
    int etv [8];
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    rst_n_nx = 1'b0;
    rv = '0; rl = '0; rd = '0; txr0 = 1'b1;
    rv3 = '0; rv3_nx = '0; rl3 = '0; rd3 = '0; tr3 = 1'b1;
    rdy_wait = 0;
    log_n    = 0;
    for (int i = 0; i < 4; i++) begin
      phead[i] = 0; ptail[i] = 0; hold[i] = 1'b0; rdy_hi[i] = 0;
    end

    // All four requesters hold a one-byte packet from reset.
    for (int i = 0; i < 4; i++) load(i, 8'h10 + 8'(i), 1'b1);
    repeat (3) step();
    check("rst_txv", txv0, 0);
    check("rst_rdy", rr0, 0);
    check("rst_busy", busy0, 0);
    check("rst_txd", txd0, 0);
    check("rst_gid", gid0, 0);
    rst_n_nx = 1'b1;
    run_bytes("all4", 4);
    repeat (4) step();
    for (int i = 0; i < 4; i++) begin
      expect_log("all4", i, i, 8'h10 + 8'(i));
      check($sformatf("all4_pulse%0d", i), rdy_hi[i], 1);
    end

    // Lone requester 2, three bytes; grant one cycle after valid.
    log_n = 0;
    load(2, 8'h41, 1'b0); load(2, 8'h42, 1'b0); load(2, 8'h43, 1'b1);
    step();
    check("t1_arb_busy", busy0, 0);
    step();
    check("t1_gid", gid0, 2);
    check("t1_busy", busy0, 1);
    run_bytes("t1", 3);
    repeat (4) step();
    expect_log("t1", 0, 2, 8'h41);
    expect_log("t1", 1, 2, 8'h42);
    expect_log("t1", 2, 2, 8'h43);

    // rr_ptr now 3: simultaneous requests served 3,0,1,2.
    log_n = 0;
    for (int i = 0; i < 4; i++) load(i, 8'h50 + 8'(i), 1'b1);
    run_bytes("rr", 4);
    repeat (4) step();
    expect_log("rr", 0, 3, 8'h53);
    expect_log("rr", 1, 0, 8'h50);
    expect_log("rr", 2, 1, 8'h51);
    expect_log("rr", 3, 2, 8'h52);

    // Two streaming requesters alternate whole packets.
    log_n = 0;
    for (int p = 0; p < 3; p++) begin
      load(0, 8'hA0 + 8'(2*p), 1'b0); load(0, 8'hA1 + 8'(2*p), 1'b1);
      load(1, 8'hB0 + 8'(2*p), 1'b0); load(1, 8'hB1 + 8'(2*p), 1'b1);
    end
    run_bytes("alt", 12);
    repeat (4) step();
    for (int p = 0; p < 3; p++) begin
      expect_log("alt", 4*p,     0, 8'hA0 + 8'(2*p));
      expect_log("alt", 4*p + 1, 0, 8'hA1 + 8'(2*p));
      expect_log("alt", 4*p + 2, 1, 8'hB0 + 8'(2*p));
      expect_log("alt", 4*p + 3, 1, 8'hB1 + 8'(2*p));
    end

    // Owner 0 stalls 20 cycles mid-packet while requester 1 waits.
    log_n = 0;
    load(0, 8'hC0, 1'b0); load(0, 8'hC1, 1'b0); load(0, 8'hC2, 1'b1);
    load(1, 8'hD0, 1'b1);
    run_bytes("stall_first", 1);
    hold[0] = 1'b1;
    viol = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (txv0 !== 1'b0 || rr0[1] !== 1'b0 || gid0 !== 2'd0 || busy0 !== 1'b1) viol++;
    end
    check("stall_viol", viol, 0);
    check("stall_nobyte", log_n, 1);
    hold[0] = 1'b0;
    run_bytes("stall", 4);
    repeat (4) step();
    expect_log("stall", 0, 0, 8'hC0);
    expect_log("stall", 1, 0, 8'hC1);
    expect_log("stall", 2, 0, 8'hC2);
    expect_log("stall", 3, 1, 8'hD0);

    // Reset during the second byte of requester 3's packet.
    log_n = 0;
    load(3, 8'hE0, 1'b0); load(3, 8'hE1, 1'b0); load(3, 8'hE2, 1'b1);
    run_bytes("mid_first", 1);
    rst_n_nx = 1'b0;
    phead[3] = ptail[3];
    step();
    check("mid_rst_txv", txv0, 0);
    check("mid_rst_rdy", rr0, 0);
    rst_n_nx = 1'b1;
    step();
    check("mid_busy", busy0, 0);
    check("mid_txv", txv0, 0);
    check("mid_rdy", rr0, 0);
    check("mid_gid", gid0, 0);
    check("mid_txd", txd0, 0);
    log_n = 0;
    load(2, 8'hF2, 1'b1);
    load(0, 8'hF0, 1'b1);
    run_bytes("post", 2);
    repeat (4) step();
    expect_log("post", 0, 0, 8'hF0);
    expect_log("post", 1, 2, 8'hF2);

    // GAP_CYCLES=3 instance: requesters 1 and 3 each send one byte.
    rd3 = {8'h33, 8'h00, 8'h31, 8'h00};
    rl3 = 4'b1010;
    rv3_nx = 4'b1010;
    eb  = '{0, 1, 1, 1, 1, 0, 1, 1};
    etv = '{0, 1, 0, 0, 0, 0, 1, 0};
    for (int c = 0; c < 8; c++) begin
      step();
      check($sformatf("gap_busy%0d", c), busy3, eb[c]);
      check($sformatf("gap_txv%0d", c), txv3, etv[c]);
      if (c == 1) begin
        check("gap_gid1", gid3, 1);
        check("gap_txd1", txd3, 8'h31);
        check("gap_rdy1", rr3, 4'b0010);
        rv3_nx = 4'b1000;
      end
      if (c >= 2 && c <= 4) check($sformatf("gap_rdy%0d", c), rr3, 0);
      if (c == 5) check("gap_idle_txd", txd3, 0);
      if (c == 6) begin
        check("gap_gid6", gid3, 3);
        check("gap_txd6", txd3, 8'h33);
        check("gap_rdy6", rr3, 4'b1000);
        rv3_nx = 4'b0000;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
